irq_arbiter_n: RTL and testbench

Parametrised next-generation machine-mode interrupt controller for the CPU core. It generalises the two-source (external/timer) controller to NUM_SRC sources with the following features:
- per-source level/edge mode
- per-source enables plus a global enable
- fixed priority arbitration with a cause ID output
- WFI sleep/wake and a MRET-terminated handler state.

It sits between the peripheral interrupt lines and the core's CSR/PC-redirect logic.

---
 rtl/irq_arbiter_n.sv | 143 ++++++++++++++
 tb/tb_irq_arbiter_n.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter_n
// Description : Machine-mode interrupt controller for NUM_SRC sources.
//               Per-source level/edge detection, per-source and global
//               enables, fixed-priority arbitration (index 0 highest),
//               WFI sleep/wake and an MRET-terminated handler state.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter_n #(
    parameter int                   NUM_SRC   = 4,
    parameter int                   ID_W      = 2,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               wfi,
    input  logic               mret,
    input  logic               global_ie,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               interrupt_taken,
    output logic [ID_W-1:0]    interrupt_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               wfi_mode,
    output logic               in_handler
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_HANDLE = 2'd1,
        ST_WFI    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_taken;
    logic [NUM_SRC-1:0] w_pend_raw;
    logic [NUM_SRC-1:0] w_enabled;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_grant;
    logic [ID_W-1:0]    w_win_id;

    // Per-source pending generation: level lines pass straight through,
    // edge lines keep a sticky set-register cleared when the source is taken.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        if (EDGE_MASK[i]) begin : g_edge
            logic r_q;
            logic r_set;
            logic w_edge;

            assign w_edge = src_irq[i] & ~r_q;

            // Previous-sample and sticky pending; a fresh edge beats the clear.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q   <= 1'b0;
                    r_set <= 1'b0;
                end else begin
                    r_q   <= src_irq[i];
                    r_set <= w_edge | (r_set & ~(w_taken & w_grant[i]));
                end
            end

            // The edge is visible in the same cycle it is detected.
            assign w_pend_raw[i] = r_set | w_edge;
        end else begin : g_level
            assign w_pend_raw[i] = src_irq[i];
        end
    end

    assign w_enabled  = w_pend_raw & src_en;
    assign w_eligible = global_ie ? w_enabled : '0;

    // Fixed-priority pick: lowest set index of the eligible vector wins.
    always_comb begin
        logic found;
        w_grant  = '0;
        w_win_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && !found) begin
                w_grant[i] = 1'b1;
                w_win_id   = ID_W'(i);
                found      = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and trap decision; a trap is taken in the cycle it becomes eligible.
    always_comb begin
        w_state_next = r_state;
        w_taken      = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (w_eligible != '0) begin
                    if (!stall) begin
                        w_taken      = 1'b1;
                        w_state_next = ST_HANDLE;
                    end
                end else if (wfi) begin
                    w_state_next = ST_WFI;
                end
            end
            ST_HANDLE: begin
                if (mret) begin
                    w_state_next = ST_NORMAL;
                end
            end
            ST_WFI: begin
                // Core is idle here, so stall does not hold off the trap.
                if (w_eligible != '0) begin
                    w_taken      = 1'b1;
                    w_state_next = ST_HANDLE;
                end else if (w_enabled != '0) begin
                    w_state_next = ST_NORMAL;
                end
            end
            default: begin
                w_state_next = ST_NORMAL;
            end
        endcase
    end

    // Combinational outputs are forced quiet while reset is asserted.
    assign interrupt_taken = w_taken & ~rst;
    assign interrupt_id    = interrupt_taken ? w_win_id : '0;
    assign pending         = rst ? '0 : w_pend_raw;
    assign wfi_mode        = (r_state == ST_WFI);
    assign in_handler      = (r_state == ST_HANDLE);

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_arbiter_n
// Description : Directed scoreboard bench for irq_arbiter_n (source 0 edge,
//               sources 1..3 level).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       wfi = 1'b0;
    logic       mret = 1'b0;
    logic       global_ie = 1'b0;
    logic [3:0] src_en = 4'h0;
    logic [3:0] src_irq = 4'h0;
    logic       interrupt_taken;
    logic [1:0] interrupt_id;
    logic [3:0] pending;
    logic       wfi_mode;
    logic       in_handler;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       taken;
        logic [1:0] id;
        logic [3:0] pend;
        logic       wfi;
        logic       hnd;
    } exp_t;

    exp_t sb[$];

    irq_arbiter_n #(
        .NUM_SRC   (4),
        .ID_W      (2),
        .EDGE_MASK (4'b0001)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .wfi             (wfi),
        .mret            (mret),
        .global_ie       (global_ie),
        .src_en          (src_en),
        .src_irq         (src_irq),
        .interrupt_taken (interrupt_taken),
        .interrupt_id    (interrupt_id),
        .pending         (pending),
        .wfi_mode        (wfi_mode),
        .in_handler      (in_handler)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic et, input logic [1:0] eid,
                            input logic [3:0] ep, input logic ew, input logic eh);
        exp_t e;
        e.tag = tag; e.taken = et; e.id = eid; e.pend = ep; e.wfi = ew; e.hnd = eh;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_exp();
        exp_t e;
        e = sb.pop_front();
        cmp(e.tag, "taken",   {3'b0, interrupt_taken}, {3'b0, e.taken});
        cmp(e.tag, "id",      {2'b0, interrupt_id},    {2'b0, e.id});
        cmp(e.tag, "pending", pending,                 e.pend);
        cmp(e.tag, "wfi",     {3'b0, wfi_mode},        {3'b0, e.wfi});
        cmp(e.tag, "handler", {3'b0, in_handler},      {3'b0, e.hnd});
    endtask

    // One cycle: drive just after posedge, record expectation, compare at negedge.
    task automatic apply(input string tag, input logic st, input logic wf, input logic mr,
                         input logic gie, input logic [3:0] en, input logic [3:0] irq,
                         input logic et, input logic [1:0] eid, input logic [3:0] ep,
                         input logic ew, input logic eh);
        @(posedge clk);
        #1;
        stall = st; wfi = wf; mret = mr; global_ie = gie; src_en = en; src_irq = irq;
        push_exp(tag, et, eid, ep, ew, eh);
        @(negedge clk);
        check_exp();
    endtask

    initial begin
        // Reset state, with lines and enables active to show outputs are held quiet.
        global_ie = 1'b1; src_en = 4'hF; src_irq = 4'b1010;
        #2;
        push_exp("reset", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        check_exp();
        @(posedge clk);
        #1;
        rst = 1'b0; src_irq = 4'h0;

        //    tag         st   wf   mr   gie  en     irq      tk   id    pend     wfi  hnd
        // Priority among level lines 1 and 3
        apply("prio0",    0,   0,   0,   1,   4'hF, 4'b1010, 1,   2'd1, 4'b1010, 0,   0);
        apply("prio1",    0,   0,   0,   1,   4'hF, 4'b1010, 0,   2'd0, 4'b1010, 0,   1);
        apply("prio2",    0,   0,   1,   1,   4'hF, 4'b1010, 0,   2'd0, 4'b1010, 0,   1);
        apply("prio3",    0,   0,   0,   1,   4'hF, 4'b1010, 1,   2'd1, 4'b1010, 0,   0);
        apply("prio4",    0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // Stall hold-off
        apply("stall0",   1,   0,   0,   1,   4'hF, 4'b0100, 0,   2'd0, 4'b0100, 0,   0);
        apply("stall1",   1,   0,   0,   1,   4'hF, 4'b0100, 0,   2'd0, 4'b0100, 0,   0);
        apply("stall2",   1,   0,   0,   1,   4'hF, 4'b0100, 0,   2'd0, 4'b0100, 0,   0);
        apply("stall3",   0,   0,   0,   1,   4'hF, 4'b0100, 1,   2'd2, 4'b0100, 0,   0);
        apply("stall4",   0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // Edge latching on source 0 while in HANDLE
        apply("edge0",    0,   0,   0,   1,   4'hF, 4'b1000, 1,   2'd3, 4'b1000, 0,   0);
        apply("edge1",    0,   0,   0,   1,   4'hF, 4'b0001, 0,   2'd0, 4'b0001, 0,   1);
        apply("edge2",    0,   0,   0,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0001, 0,   1);
        apply("edge3",    0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0001, 0,   1);
        apply("edge4",    0,   0,   0,   1,   4'hF, 4'b0000, 1,   2'd0, 4'b0001, 0,   0);
        apply("edge5",    0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // Edge taken in its own cycle: set wins over the clear
        apply("setwin0",  0,   0,   0,   1,   4'hF, 4'b0001, 1,   2'd0, 4'b0001, 0,   0);
        apply("setwin1",  0,   0,   0,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0001, 0,   1);
        apply("setwin2",  0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0001, 0,   1);
        apply("setwin3",  0,   0,   0,   1,   4'hF, 4'b0000, 1,   2'd0, 4'b0001, 0,   0);
        apply("setwin4",  0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // WFI wake with trap, stall ignored
        apply("wfit0",    0,   1,   0,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   0);
        apply("wfit1",    0,   0,   0,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 1,   0);
        apply("wfit2",    1,   0,   0,   1,   4'hF, 4'b1000, 1,   2'd3, 4'b1000, 1,   0);
        apply("wfit3",    0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // Pending interrupt beats wfi in the same cycle
        apply("beat0",    0,   1,   0,   1,   4'hF, 4'b0010, 1,   2'd1, 4'b0010, 0,   0);
        apply("beat1",    0,   0,   1,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   1);
        // WFI wake without trap (global_ie low)
        apply("wfin0",    0,   1,   0,   1,   4'hF, 4'b0000, 0,   2'd0, 4'b0000, 0,   0);
        apply("wfin1",    0,   0,   0,   0,   4'hF, 4'b0010, 0,   2'd0, 4'b0010, 1,   0);
        apply("wfin2",    0,   0,   0,   0,   4'hF, 4'b0010, 0,   2'd0, 4'b0010, 0,   0);
        // Per-source enable masks a pending line
        apply("mask0",    0,   0,   0,   1,   4'hD, 4'b0010, 0,   2'd0, 4'b0010, 0,   0);
        // Into HANDLE with an edge pending on source 0
        apply("ar0",      0,   0,   0,   1,   4'hF, 4'b1000, 1,   2'd3, 4'b1000, 0,   0);
        apply("ar1",      0,   0,   0,   1,   4'hF, 4'b0001, 0,   2'd0, 4'b0001, 0,   1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        push_exp("arst", 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
        check_exp();
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_irq = 4'b0001;
        push_exp("arel0", 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        check_exp();
        apply("arel1",    0,   0,   0,   1,   4'hF, 4'b0001, 0,   2'd0, 4'b0001, 0,   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
